// File: rtl/dsp_feeder.sv
// rtl/dsp_feeder.sv - frame writer/reader between a valid/ready stream and the dsp shift-register stub
// Optional DSP_FEEDER_LAST_EN adds m_last, flagging the final word of each frame.
module dsp_feeder #(
  parameter int BUS_WIDTH   = 24,
  parameter int FRAME_WORDS = 2,
  parameter int PARAM_W     = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [BUS_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [BUS_WIDTH-1:0] dsp_din,
  output logic                 dsp_we,
  output logic [PARAM_W-1:0]   dsp_param,
  input  logic [BUS_WIDTH-1:0] dsp_dout,
  output logic [BUS_WIDTH-1:0] m_data,
  output logic                 m_valid,
`ifdef DSP_FEEDER_LAST_EN
  output logic                 m_last,
`endif
  input  logic                 m_ready,
  output logic                 busy
);

  localparam int CW = PARAM_W + 1;
  localparam logic [CW-1:0] FW_M1 = CW'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT1 = 3'd3,
    WAIT2 = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 s_ready_q, s_ready_d;
  logic [BUS_WIDTH-1:0] dsp_din_q, dsp_din_d;
  logic                 dsp_we_q, dsp_we_d;
  logic [PARAM_W-1:0]   dsp_param_q, dsp_param_d;
  logic [BUS_WIDTH-1:0] m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 busy_q, busy_d;
  logic [CW-1:0]        wcnt_q, wcnt_d;
  logic [CW-1:0]        rcnt_q, rcnt_d;
`ifdef DSP_FEEDER_LAST_EN
  logic                 m_last_q, m_last_d;
`endif

  always_comb begin
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    dsp_din_d   = dsp_din_q;
    dsp_we_d    = 1'b0;
    dsp_param_d = dsp_param_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
`ifdef DSP_FEEDER_LAST_EN
    m_last_d    = m_last_q;
`endif
    if (en) begin
      unique case (state_q)
        IDLE: begin
          state_d   = LOAD;
          s_ready_d = 1'b1;
        end
        LOAD: begin
          if (s_valid && s_ready_q) begin
            dsp_din_d = s_data;
            dsp_we_d  = 1'b1;
            if (wcnt_q == FW_M1) begin
              wcnt_d    = '0;
              s_ready_d = 1'b0;
              state_d   = ISSUE;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
        ISSUE: begin
          // Index 0 is the newest word, so count down to read oldest first.
          dsp_param_d = PARAM_W'(FW_M1 - rcnt_q);
          state_d     = WAIT1;
        end
        WAIT1: state_d = WAIT2;
        WAIT2: begin
          m_data_d  = dsp_dout;
          m_valid_d = 1'b1;
`ifdef DSP_FEEDER_LAST_EN
          m_last_d  = (rcnt_q == FW_M1);
`endif
          state_d   = OUT;
        end
        OUT: begin
          if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
`ifdef DSP_FEEDER_LAST_EN
            m_last_d  = 1'b0;
`endif
            if (rcnt_q == FW_M1) begin
              rcnt_d  = '0;
              state_d = IDLE;
            end else begin
              rcnt_d  = rcnt_q + 1'b1;
              state_d = ISSUE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      s_ready_q   <= 1'b0;
      dsp_din_q   <= '0;
      dsp_we_q    <= 1'b0;
      dsp_param_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
`ifdef DSP_FEEDER_LAST_EN
      m_last_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      dsp_din_q   <= dsp_din_d;
      dsp_we_q    <= dsp_we_d;
      dsp_param_q <= dsp_param_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
`ifdef DSP_FEEDER_LAST_EN
      m_last_q    <= m_last_d;
`endif
    end
  end

  assign s_ready   = s_ready_q;
  assign dsp_din   = dsp_din_q;
  assign dsp_we    = dsp_we_q;
  assign dsp_param = dsp_param_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign busy      = busy_q;
`ifdef DSP_FEEDER_LAST_EN
  assign m_last    = m_last_q;
`endif

endmodule

// File: tb/tb_dsp_feeder.sv
// tb/tb_dsp_feeder.sv - scoreboard bench for dsp_feeder with a behavioural dsp shift-register stub
module tb_dsp_feeder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] dsp_din;
  logic        dsp_we;
  logic [7:0]  dsp_param;
  logic [23:0] dsp_dout;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
`ifdef DSP_FEEDER_LAST_EN
  logic        m_last;
`endif

  always #5 clk = ~clk;

  dsp_feeder #(.BUS_WIDTH(24), .FRAME_WORDS(2), .PARAM_W(8)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dsp_din(dsp_din), .dsp_we(dsp_we), .dsp_param(dsp_param), .dsp_dout(dsp_dout),
    .m_data(m_data), .m_valid(m_valid),
`ifdef DSP_FEEDER_LAST_EN
    .m_last(m_last),
`endif
    .m_ready(m_ready), .busy(busy)
  );

  // dsp stub: slot 0 is newest, dout is registered from param
  logic [23:0] dmem [0:3];
  always @(posedge clk) begin
    if (dsp_we) begin
      dmem[3] <= dmem[2];
      dmem[2] <= dmem[1];
      dmem[1] <= dmem[0];
      dmem[0] <= dsp_din;
    end
    dsp_dout <= dmem[dsp_param[1:0]];
  end

  typedef struct packed {
    logic        last;
    logic [23:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] we_q[$];
  logic [7:0]  plog[$];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [7:0]  prev_param = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (dsp_we) begin
        if (we_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dsp_we_unexpected actual=1 required=0 din=%0h", dsp_din);
        end else begin
          chk("dsp_din", {8'd0, dsp_din}, {8'd0, we_q.pop_front()});
        end
        we_cnt <= we_cnt + 1;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_unexpected actual=%0h required=none", m_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("m_data", {8'd0, m_data}, {8'd0, e.data});
`ifdef DSP_FEEDER_LAST_EN
          chk("m_last", {31'd0, m_last}, {31'd0, e.last});
`endif
        end
      end
      if (dsp_param != prev_param) begin
        plog.push_back(dsp_param);
        prev_param <= dsp_param;
      end
    end
  end

  task automatic send_word(input logic [23:0] d, input bit last, input bit abort);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout actual=0 required=1");
    end else if (!abort) begin
      we_q.push_back(d);
      exp_q.push_back({last, d});
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] a, input logic [23:0] b);
    send_word(a, 1'b0, 1'b0);
    send_word(b, 1'b1, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_ready_high();
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_s_ready", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_dsp_we"}, {31'd0, dsp_we}, 32'd0);
    chk({tag, "_dsp_din"}, {8'd0, dsp_din}, 32'd0);
    chk({tag, "_dsp_param"}, {24'd0, dsp_param}, 32'd0);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_m_data"}, {8'd0, m_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
`ifdef DSP_FEEDER_LAST_EN
    chk({tag, "_m_last"}, {31'd0, m_last}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    logic [23:0] hold;
    logic [23:0] tog [0:5];
    rstn    = 1'b0;
    en      = 1'b1;
    s_data  = 24'd0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    #2;
    check_all_zero("reset");
    #20;
    rstn = 1'b1;

    // 1: basic frame
    we0 = we_cnt;
    send_frame(24'h00A1B2, 24'h00C3D4);
    wait_idle("t1_busy_idle");
    chk("t1_we_pulses", we_cnt - we0, 32'd2);
    chk("t1_drained", exp_q.size(), 32'd0);

    // 2: backpressure in OUT
    m_ready = 1'b0;
    send_frame(24'h123456, 24'h654321);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!m_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t2_m_valid_seen", {31'd0, m_valid}, 32'd1);
    hold = m_data;
    chk("t2_first_word", {8'd0, hold}, 32'h00123456);
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold_valid", {31'd0, m_valid}, 32'd1);
      chk("t2_hold_data", {8'd0, m_data}, {8'd0, hold});
      chk("t2_s_ready_low", {31'd0, s_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_valid_drop", {31'd0, m_valid}, 32'd0);
    wait_idle("t2_busy_idle");

    // 3: s_valid toggling, only accepted words written
    tog[0] = 24'h0000AA; tog[1] = 24'hDEAD01; tog[2] = 24'h0000BB;
    tog[3] = 24'hDEAD03; tog[4] = 24'hDEAD04; tog[5] = 24'hDEAD05;
    plog.delete();
    we0 = we_cnt;
    wait_ready_high();
    we_q.push_back(24'h0000AA);
    exp_q.push_back({1'b0, 24'h0000AA});
    we_q.push_back(24'h0000BB);
    exp_q.push_back({1'b1, 24'h0000BB});
    for (int i = 0; i < 6; i++) begin
      s_valid = (i % 2 == 0);
      s_data  = tog[i];
      @(negedge clk);
    end
    s_valid = 1'b0;
    wait_idle("t3_busy_idle");
    chk("t3_we_pulses", we_cnt - we0, 32'd2);
    chk("t3_param_changes", plog.size(), 32'd2);
    if (plog.size() == 2) begin
      chk("t3_param_first", {24'd0, plog[0]}, 32'd1);
      chk("t3_param_second", {24'd0, plog[1]}, 32'd0);
    end

    // 4: en low in WAIT1
    send_frame(24'h0BEEF0, 24'h0CAFE0);
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t4_we_low", {31'd0, dsp_we}, 32'd0);
      chk("t4_m_valid_low", {31'd0, m_valid}, 32'd0);
      chk("t4_param_hold", {24'd0, dsp_param}, 32'd1);
    end
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_wait2_no_valid", {31'd0, m_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("t4_valid_after_resume", {31'd0, m_valid}, 32'd1);
    chk("t4_data_after_resume", {8'd0, m_data}, 32'h000BEEF0);
    wait_idle("t4_busy_idle");

    // 5: asynchronous reset mid-LOAD
    send_word(24'h00F00D, 1'b0, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("t5_abort");
    #13;
    rstn = 1'b1;
    send_frame(24'h000011, 24'h000022);
    wait_idle("t5_busy_idle");

    // 6: three back-to-back frames
    send_frame(24'h000101, 24'h000102);
    send_frame(24'h000201, 24'h000202);
    send_frame(24'h000301, 24'h000302);
    wait_idle("t6_busy_idle");

    chk("final_exp_empty", exp_q.size(), 32'd0);
    chk("final_we_empty", we_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
